// File: rtl/path_delay_probe_ctrl_if.sv
// Control/status bundle between the measurement register block (master)
// and path_delay_probe_ctrl (slave).
//   start, abort      : run request / cancel from the register block
//   wait_cycles       : launch-to-capture distance minus 1
//   num_trials        : trials per run
//   busy, done        : run status; done is a one-cycle end-of-run pulse
//   err_count         : saturating mismatch count of the current/last run
//   trial_count       : completed trials of the current/last run
//   last_sample       : most recent captured path value
interface path_delay_probe_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 8
);
  logic              start;
  logic              abort;
  logic [WAIT_W-1:0] wait_cycles;
  logic [CNT_W-1:0]  num_trials;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  trial_count;
  logic              last_sample;

  modport master (
    output start, abort, wait_cycles, num_trials,
    input  busy, done, err_count, trial_count, last_sample
  );

  modport slave (
    input  start, abort, wait_cycles, num_trials,
    output busy, done, err_count, trial_count, last_sample
  );
endinterface

// File: rtl/path_delay_probe_ctrl.sv
// Sequences launch/capture timing trials on one chained delay path and
// counts capture mismatches over a programmed number of trials.
//   clk, rst_n  : single clock, asynchronous active-low reset
//   ctl         : control/status bundle (path_delay_probe_ctrl_if.slave)
//   path_input  : registered drive into the delay path (toggles per launch)
//   path_result : delay path output, asynchronous to clk
// Optional macro PATH_PROBE_SYNC_EN: path_result goes through a 2-flop
// synchronizer; the capture edge is unchanged and CAPTURE lasts 2 extra
// cycles so the compare uses the sample taken at the capture edge.
module path_delay_probe_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WAIT_W        = 8,
  parameter int INVERTING     = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  path_delay_probe_ctrl_if.slave ctl,
  output logic                   path_input,
  input  logic                   path_result
);

  localparam int   SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic INV   = (INVERTING != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SETTLE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_lat, wait_cnt;
  logic [CNT_W-1:0]  num_lat, err_q, trial_q;
  logic [SET_W-1:0]  settle_cnt;
  logic              cap_bit, last_q, busy;
  logic              cap_dly_done;

`ifdef PATH_PROBE_SYNC_EN
  logic       sync1, sync2;
  logic [1:0] cap_dly;

  // sync1 takes the capture-edge sample; it reaches sync2 one edge later and
  // is parked in cap_bit on the following edge, before sync2 moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cap_dly <= '0;
      cap_bit <= 1'b0;
    end else begin
      sync1 <= path_result;
      sync2 <= sync1;
      if (state == S_WAIT)
        cap_dly <= 2'd2;
      else if (state == S_CAPTURE && cap_dly != 2'd0)
        cap_dly <= cap_dly - 2'd1;
      if (state == S_CAPTURE && cap_dly == 2'd1)
        cap_bit <= sync2;
    end
  end

  assign cap_dly_done = (cap_dly == 2'd0);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cap_bit <= 1'b0;
    else if (state == S_WAIT && wait_cnt == '0)
      cap_bit <= path_result;
  end

  assign cap_dly_done = 1'b1;
`endif

  assign busy = (state == S_LAUNCH) || (state == S_WAIT) ||
                (state == S_CAPTURE) || (state == S_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (ctl.start)
                   state_nxt = (ctl.num_trials == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT:    if (wait_cnt == '0) state_nxt = S_CAPTURE;
      S_CAPTURE: if (cap_dly_done) state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == '0)
                   state_nxt = (trial_q == num_lat) ? S_DONE : S_LAUNCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (ctl.abort && busy) state_nxt = S_IDLE;
  end

  // Launch and capture updates are suppressed when abort lands in the same
  // cycle, so an aborted run leaves path_input and the counters untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_input <= 1'b0;
      wait_lat   <= '0;
      wait_cnt   <= '0;
      num_lat    <= '0;
      err_q      <= '0;
      trial_q    <= '0;
      settle_cnt <= '0;
      last_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (ctl.start) begin
          wait_lat <= ctl.wait_cycles;
          num_lat  <= ctl.num_trials;
          err_q    <= '0;
          trial_q  <= '0;
        end
        S_LAUNCH: if (!ctl.abort) begin
          path_input <= ~path_input;
          wait_cnt   <= wait_lat;
        end
        S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        S_CAPTURE: if (!ctl.abort && cap_dly_done) begin
          last_q <= cap_bit;
          if (cap_bit != (path_input ^ INV) && err_q != '1)
            err_q <= err_q + CNT_W'(1);
          trial_q    <= trial_q + CNT_W'(1);
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
        end
        S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        default: ;
      endcase
    end
  end

  assign ctl.busy        = busy;
  assign ctl.done        = (state == S_DONE);
  assign ctl.err_count   = err_q;
  assign ctl.trial_count = trial_q;
  assign ctl.last_sample = last_q;

endmodule

// File: tb/tb_path_delay_probe_ctrl.sv
module tb_path_delay_probe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  wc = '0;
  logic [15:0] nt = '0;
  logic        inv_sel = 1'b0;

  logic pin_a, pin_b, pin_c;
  logic dly_a = 1'b0, dly_b = 1'b0, dly_c = 1'b0;
  logic res_a, res_b, res_c;

  int total = 0;
  int bad = 0;
  int tog, dn, done_at, busy_seen;
  logic p0;

  always #5 clk = ~clk;

  // Delay path: 3.5-clock transport delay; dut_b sees an inverting path.
  always @(pin_a) dly_a <= #35 pin_a;
  always @(pin_b) dly_b <= #35 pin_b;
  always @(pin_c) dly_c <= #35 pin_c;
  assign res_a = inv_sel ? ~dly_a : dly_a;
  assign res_b = ~dly_b;
  assign res_c = dly_c;

  path_delay_probe_ctrl_if #(.CNT_W(16), .WAIT_W(8)) ia ();
  path_delay_probe_ctrl_if #(.CNT_W(16), .WAIT_W(8)) ib ();
  path_delay_probe_ctrl_if #(.CNT_W(2),  .WAIT_W(8)) ic ();

  assign ia.start = start;  assign ia.abort = abort;
  assign ia.wait_cycles = wc;  assign ia.num_trials = nt;
  assign ib.start = start;  assign ib.abort = abort;
  assign ib.wait_cycles = wc;  assign ib.num_trials = nt;
  assign ic.start = start;  assign ic.abort = abort;
  assign ic.wait_cycles = wc;  assign ic.num_trials = nt[1:0];

  path_delay_probe_ctrl #(.CNT_W(16), .WAIT_W(8), .INVERTING(0), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctl(ia), .path_input(pin_a), .path_result(res_a));
  path_delay_probe_ctrl #(.CNT_W(16), .WAIT_W(8), .INVERTING(1), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctl(ib), .path_input(pin_b), .path_result(res_b));
  path_delay_probe_ctrl #(.CNT_W(2), .WAIT_W(8), .INVERTING(0), .SETTLE_CYCLES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .ctl(ic), .path_input(pin_c), .path_result(res_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches dut_a cycle by cycle (sampled 1ns after each
  // edge). Cycle i is the state after the i-th edge following start.
  task automatic do_run(input int w, input int n, input int maxc, input int abort_at);
    logic prev;
    wc = 8'(w);
    nt = 16'(n);
    tog = 0; dn = 0; done_at = 0; busy_seen = 0;
    prev = pin_a;
    start = 1'b1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (pin_a !== prev) begin tog++; prev = pin_a; end
      if (ia.busy === 1'b1) busy_seen = 1;
      if (ia.done === 1'b1) begin
        if (dn == 0) done_at = i;
        dn++;
      end
      if (i == 1) start = 1'b0;
      if (i == abort_at) begin abort = 1'b1; start = 1'b1; end
      if (i == abort_at + 1) begin abort = 1'b0; start = 1'b0; end
      if (dn > 0 && i >= done_at + 3) break;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pin"},   32'(pin_a), 0);
    chk({tag, "_busy"},  32'(ia.busy), 0);
    chk({tag, "_done"},  32'(ia.done), 0);
    chk({tag, "_err"},   32'(ia.err_count), 0);
    chk({tag, "_trial"}, 32'(ia.trial_count), 0);
    chk({tag, "_last"},  32'(ia.last_sample), 0);
  endtask

  initial begin
    #23;
    chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // wc=5: capture 6 edges after launch, path settled. Period 12.
    do_run(5, 4, 80, 0);
    chk("r1_done_at", done_at, 49);
    chk("r1_done_cnt", dn, 1);
    chk("r1_toggles", tog, 4);
    chk("r1_err", ia.err_count, 0);
    chk("r1_trial", ia.trial_count, 4);
    chk("r1_busy_end", ia.busy, 0);
    chk("r1_last", ia.last_sample, 0);
    chk("r1_err_inv", ib.err_count, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in WAIT of trial 1, path_input already launched high.
    wc = 8'd5; nt = 16'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pin_launched", pin_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    #2 rst_n = 1'b1;
    do_run(5, 4, 80, 0);
    chk("rr_done_at", done_at, 49);
    chk("rr_toggles", tog, 4);
    chk("rr_trial", ia.trial_count, 4);
    chk("rr_err", ia.err_count, 0);
    repeat (3) @(posedge clk);
    #1;

    // wc=1: every capture precedes the path edge.
    do_run(1, 4, 60, 0);
    chk("r2_done_at", done_at, 33);
    chk("r2_err", ia.err_count, 4);
    chk("r2_trial", ia.trial_count, 4);
    chk("r2_last", ia.last_sample, 1);
    repeat (3) @(posedge clk);
    #1;

    // Inverting path: INVERTING=1 matches, INVERTING=0 misses every trial.
    inv_sel = 1'b1;
    @(posedge clk); #1;
    do_run(10, 3, 80, 0);
    chk("r3_done_at", done_at, 52);
    chk("r3_err_inv1", ib.err_count, 0);
    chk("r3_trial_inv1", ib.trial_count, 3);
    chk("r3_err_inv0", ia.err_count, 3);
    inv_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Zero trials: straight to DONE.
    do_run(5, 0, 20, 0);
    chk("r4_done_at", done_at, 1);
    chk("r4_done_cnt", dn, 1);
    chk("r4_toggles", tog, 0);
    chk("r4_busy_seen", busy_seen, 0);
    chk("r4_err", ia.err_count, 0);
    chk("r4_trial", ia.trial_count, 0);
    repeat (3) @(posedge clk);
    #1;

    // Abort in WAIT of trial 2 of 5, with start asserted in the abort cycle.
    p0 = pin_a;
    do_run(5, 5, 25, 15);
    chk("ab_done_cnt", dn, 0);
    chk("ab_busy", ia.busy, 0);
    chk("ab_trial", ia.trial_count, 1);
    chk("ab_err", ia.err_count, 0);
    chk("ab_toggles", tog, 2);
    chk("ab_pin", pin_a, 32'(p0));
    do_run(5, 2, 60, 0);
    chk("ab2_done_at", done_at, 25);
    chk("ab2_trial", ia.trial_count, 2);
    chk("ab2_toggles", tog, 2);
    repeat (20) @(posedge clk);
    #1;

    // CNT_W=2: three failing trials fill the counter without wrapping.
    do_run(1, 3, 60, 0);
    chk("sat_err_c", ic.err_count, 3);
    chk("sat_trial_c", ic.trial_count, 3);
    chk("sat_err_a", ia.err_count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
